// File: rtl/mac_feeder.sv
// Issue side of a 4-lane MAC datapath: buffers packed a/b vectors in a small FIFO and
// serializes them into an external MAC, feeding the MAC result back as the next c.
module mac_feeder #(
  parameter int bw      = 4,
  parameter int psum_bw = 16,
  parameter int DEPTH   = 4,
  parameter int MAC_LAT = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [7:0]         len,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [4*bw-1:0]    in_a,
  input  logic [4*bw-1:0]    in_b,
  output logic [bw-1:0]      a0,
  output logic [bw-1:0]      a1,
  output logic [bw-1:0]      a2,
  output logic [bw-1:0]      a3,
  output logic [bw-1:0]      b0,
  output logic [bw-1:0]      b1,
  output logic [bw-1:0]      b2,
  output logic [bw-1:0]      b3,
  output logic [psum_bw-1:0] c,
  input  logic [psum_bw-1:0] mac_out,
  output logic [psum_bw-1:0] psum_out,
  output logic               psum_valid,
  output logic               busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [WW-1:0] WAIT_END = WW'(MAC_LAT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [4*bw-1:0]    fa_q [DEPTH];
  logic [4*bw-1:0]    fb_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [AW:0]        count_q;
  logic               push_s, pop_s;

  logic [7:0]         len_q, len_d;
  logic [7:0]         cnt_q, cnt_d, cnt_inc_s;
  logic [WW-1:0]      wcnt_q, wcnt_d;
  logic [psum_bw-1:0] acc_q, acc_d;
  logic [4*bw-1:0]    opa_q, opa_d, opb_q, opb_d;
  logic [psum_bw-1:0] c_q, c_d, psum_q, psum_d;
  logic               pv_q, pv_d, busy_q, busy_d;

  // A freed slot only becomes visible the cycle after the pop, since in_ready decodes count_q.
  assign in_ready  = (count_q != FULL_CNT);
  assign push_s    = in_valid && in_ready;
  assign pop_s     = (state_q == LOAD) && (count_q != '0);
  assign cnt_inc_s = cnt_q + 8'd1;

  // FIFO storage, pointers and occupancy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        fa_q[i] <= '0;
        fb_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_s) begin
        fa_q[wr_ptr_q] <= in_a;
        fb_q[wr_ptr_q] <= in_b;
        wr_ptr_q       <= wr_ptr_q + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Next-state and datapath-register decode for the issue FSM
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    wcnt_d  = wcnt_q;
    acc_d   = acc_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    c_d     = c_q;
    psum_d  = psum_q;
    pv_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          len_d   = len;
          acc_d   = '0;
          cnt_d   = 8'd0;
          state_d = (len != 8'd0) ? LOAD : DONE;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        if (count_q != '0) begin
          opa_d   = fa_q[rd_ptr_q];
          opb_d   = fb_q[rd_ptr_q];
          c_d     = acc_q;
          wcnt_d  = '0;
          state_d = WAIT;
        end else begin
          state_d = LOAD;
        end
      end
      WAIT: begin
        wcnt_d = wcnt_q + WW'(1);
        if (wcnt_q == WAIT_END) begin
          acc_d   = mac_out;
          cnt_d   = cnt_inc_s;
          state_d = (cnt_inc_s == len_q) ? DONE : LOAD;
        end else begin
          state_d = WAIT;
        end
      end
      DONE: begin
        psum_d  = acc_q;
        pv_d    = 1'b1;
        opa_d   = '0;
        opb_d   = '0;
        c_d     = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // FSM and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      len_q   <= 8'd0;
      cnt_q   <= 8'd0;
      wcnt_q  <= '0;
      acc_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      c_q     <= '0;
      psum_q  <= '0;
      pv_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      wcnt_q  <= wcnt_d;
      acc_q   <= acc_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      c_q     <= c_d;
      psum_q  <= psum_d;
      pv_q    <= pv_d;
      busy_q  <= busy_d;
    end
  end

  assign a0 = opa_q[bw-1:0];
  assign a1 = opa_q[2*bw-1:bw];
  assign a2 = opa_q[3*bw-1:2*bw];
  assign a3 = opa_q[4*bw-1:3*bw];
  assign b0 = opb_q[bw-1:0];
  assign b1 = opb_q[2*bw-1:bw];
  assign b2 = opb_q[3*bw-1:2*bw];
  assign b3 = opb_q[4*bw-1:3*bw];
  assign c          = c_q;
  assign psum_out   = psum_q;
  assign psum_valid = pv_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_mac_feeder.sv
// Directed bench for mac_feeder: a behavioural combinational MAC closes the c->out loop.
module tb_mac_feeder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, start, in_valid, in_ready, psum_valid, busy;
  logic [7:0]  len;
  logic [15:0] in_a, in_b, c, mac_out, psum_out;
  logic [3:0]  a0, a1, a2, a3, b0, b1, b2, b3;

  logic        start8, in_valid8, in_ready8, psum_valid8, busy8;
  logic [7:0]  len8, c8, mac_out8, psum_out8;
  logic [15:0] in_a8, in_b8, m8_full;
  logic [3:0]  a0_8, a1_8, a2_8, a3_8, b0_8, b1_8, b2_8, b3_8;

  int checks = 0;
  int failures = 0;
  int pv_cnt = 0;
  logic [47:0] oplog [$];
  logic [47:0] prev_op = 48'd0;
  logic [47:0] cur_op;

  function automatic logic [15:0] mac16(input logic [15:0] av, input logic [15:0] bv,
                                        input logic [15:0] cc);
    int s;
    s = int'(cc);
    for (int k = 0; k < 4; k++) begin
      s = s + int'(av[k*4 +: 4]) * int'($signed(bv[k*4 +: 4]));
    end
    return s[15:0];
  endfunction

  assign mac_out  = mac16({a3, a2, a1, a0}, {b3, b2, b1, b0}, c);
  assign m8_full  = mac16({a3_8, a2_8, a1_8, a0_8}, {b3_8, b2_8, b1_8, b0_8}, {8'd0, c8});
  assign mac_out8 = m8_full[7:0];
  assign cur_op   = {a3, a2, a1, a0, b3, b2, b1, b0, c};

  mac_feeder #(.bw(4), .psum_bw(16), .DEPTH(4), .MAC_LAT(1)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .a0(a0), .a1(a1), .a2(a2), .a3(a3), .b0(b0), .b1(b1), .b2(b2), .b3(b3),
    .c(c), .mac_out(mac_out), .psum_out(psum_out), .psum_valid(psum_valid), .busy(busy)
  );

  mac_feeder #(.bw(4), .psum_bw(8), .DEPTH(4), .MAC_LAT(1)) dut8 (
    .clk(clk), .reset_n(reset_n), .start(start8), .len(len8),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_a(in_a8), .in_b(in_b8),
    .a0(a0_8), .a1(a1_8), .a2(a2_8), .a3(a3_8), .b0(b0_8), .b1(b1_8), .b2(b2_8), .b3(b3_8),
    .c(c8), .mac_out(mac_out8), .psum_out(psum_out8), .psum_valid(psum_valid8), .busy(busy8)
  );

  // Count psum_valid cycles and log every new operand set presented to the MAC.
  always @(negedge clk) begin
    if (psum_valid) pv_cnt <= pv_cnt + 1;
    if (cur_op != prev_op && cur_op[47:16] != 32'd0) oplog.push_back(cur_op);
    prev_op <= cur_op;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] a, input logic [15:0] b);
    logic ok;
    ok = 1'b0;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      ok = in_ready;
      step();
    end
    in_valid = 1'b0;
    if (!ok) check("push_timeout", 64'(ok), 64'd1);
  endtask

  task automatic start_run(input logic [7:0] l);
    start = 1'b1;
    len = l;
    step();
    start = 1'b0;
  endtask

  task automatic wait_psum(input string tag);
    for (int i = 0; i < 300 && !psum_valid; i++) step();
    check(tag, 64'(psum_valid), 64'd1);
  endtask

  task automatic check_log(input string tag, input int idx, input logic [47:0] exp);
    if (idx < oplog.size()) check(tag, 64'(oplog[idx]), 64'(exp));
    else check({tag, "_missing"}, 64'(oplog.size()), 64'(idx + 1));
  endtask

  logic [15:0] ta [5];
  logic [15:0] tbv [5];
  logic [15:0] acc;
  int lb, pv0;

  initial begin
    reset_n = 1'b1; start = 1'b0; len = 8'd0; in_valid = 1'b0; in_a = 16'd0; in_b = 16'd0;
    start8 = 1'b0; len8 = 8'd0; in_valid8 = 1'b0; in_a8 = 16'd0; in_b8 = 16'd0;
    #2 reset_n = 1'b0;
    #1;
    check("rst_ops", 64'({a3, a2, a1, a0, b3, b2, b1, b0}), 64'd0);
    check("rst_c_psum", 64'({c, psum_out}), 64'd0);
    check("rst_flags", 64'({psum_valid, busy, in_ready}), 64'b001);
    @(negedge clk);
    reset_n = 1'b1;
    step();

    // T1: len=5, a=15 x4, b=-8 x4, FIFO filled before start
    lb = oplog.size();
    pv0 = pv_cnt;
    for (int i = 0; i < 4; i++) push(16'hFFFF, 16'h8888);
    check("t1_full_in_ready", 64'(in_ready), 64'd0);
    check("t1_idle_busy", 64'(busy), 64'd0);
    start_run(8'd5);
    check("t1_busy", 64'(busy), 64'd1);
    push(16'hFFFF, 16'h8888);
    wait_psum("t1_psum_valid");
    check("t1_psum", 64'(psum_out), 64'hF6A0);
    step();
    step();
    check("t1_pulse_count", 64'(pv_cnt - pv0), 64'd1);
    check("t1_psum_held", 64'(psum_out), 64'hF6A0);
    check("t1_vectors", 64'(oplog.size() - lb), 64'd5);
    check("t1_idle_ops", 64'({a3, a2, a1, a0, b3, b2, b1, b0, c}), 64'd0);

    // T2: c feedback sequence 0, FFFE, FFFC
    lb = oplog.size();
    for (int i = 0; i < 3; i++) push(16'h4321, 16'hF1F1);
    start_run(8'd3);
    wait_psum("t2_psum_valid");
    check("t2_psum", 64'(psum_out), 64'hFFFA);
    check_log("t2_c0", lb,     {16'h4321, 16'hF1F1, 16'h0000});
    check_log("t2_c1", lb + 1, {16'h4321, 16'hF1F1, 16'hFFFE});
    check_log("t2_c2", lb + 2, {16'h4321, 16'hF1F1, 16'hFFFC});
    step();

    // T4: five distinct vectors, fifth held by the loader until a slot frees
    lb = oplog.size();
    for (int i = 0; i < 5; i++) begin
      ta[i]  = {4'(i + 4), 4'(i + 3), 4'(i + 2), 4'(i + 1)};
      tbv[i] = {4'(i), 4'(15 - i), 4'd2, 4'(i + 9)};
    end
    for (int i = 0; i < 4; i++) push(ta[i], tbv[i]);
    check("t4_full_in_ready", 64'(in_ready), 64'd0);
    start_run(8'd5);
    push(ta[4], tbv[4]);
    wait_psum("t4_psum_valid");
    acc = 16'd0;
    for (int i = 0; i < 5; i++) begin
      check_log($sformatf("t4_vec%0d", i), lb + i, {ta[i], tbv[i], acc});
      acc = mac16(ta[i], tbv[i], acc);
    end
    check("t4_vectors", 64'(oplog.size() - lb), 64'd5);
    check("t4_psum", 64'(psum_out), 64'(acc));
    step();

    // T3: 8-bit psum wraps: 4*15*7 = 420 -> 0xA4
    in_a8 = 16'hFFFF; in_b8 = 16'h7777; in_valid8 = 1'b1;
    step();
    in_valid8 = 1'b0;
    start8 = 1'b1; len8 = 8'd1;
    step();
    start8 = 1'b0;
    for (int i = 0; i < 20 && !psum_valid8; i++) step();
    check("t3_psum_valid", 64'(psum_valid8), 64'd1);
    check("t3_psum_wrap", 64'(psum_out8), 64'hA4);
    step();

    // T5: len=0 with one entry left in the FIFO, then len=1 with a start while busy
    push(16'h4321, 16'h2222);
    start_run(8'd0);
    check("t5_len0_busy", 64'({busy, psum_valid}), 64'b10);
    step();
    check("t5_len0_pulse", 64'(psum_valid), 64'd1);
    check("t5_len0_psum", 64'(psum_out), 64'd0);
    step();
    check("t5_len0_end", 64'({busy, psum_valid}), 64'b00);
    start_run(8'd1);
    start = 1'b1; len = 8'd7;
    step();
    start = 1'b0;
    wait_psum("t5_psum_valid");
    check("t5_leftover_psum", 64'(psum_out), 64'h0014);
    step();
    check("t5_ignored_start", 64'({busy, psum_valid}), 64'b00);

    // T6: reset while vector 2 is in WAIT, then a clean single-vector run
    push(16'h1111, 16'h1111);
    push(16'h2222, 16'h1111);
    push(16'h3333, 16'h1111);
    start_run(8'd3);
    for (int i = 0; i < 50 && a0 != 4'd2; i++) step();
    check("t6_reached_v2", 64'(a0), 64'd2);
    reset_n = 1'b0;
    #1;
    check("t6_rst_ops", 64'({a3, a2, a1, a0, b3, b2, b1, b0, c}), 64'd0);
    check("t6_rst_flags", 64'({psum_out, psum_valid, busy, in_ready}), 64'b001);
    @(negedge clk);
    reset_n = 1'b1;
    step();
    push(16'h5555, 16'h2222);
    start_run(8'd1);
    wait_psum("t6_psum_valid");
    check("t6_new_run_psum", 64'(psum_out), 64'h0028);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
